// File: rtl/dt_arbiter.sv
// Round-robin display-ownership arbiter for the seven-segment path.
// Grants one of four requesters with a guaranteed minimum hold time.
module dt_arbiter #(
  parameter int TICK_DIV   = 100000,
  parameter int HOLD_TICKS = 500
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [127:0] data_in,
  output logic [3:0]   gnt,
  output logic [1:0]   owner,
  output logic         busy,
  output logic [31:0]  num_out,
  output logic         hold_done
);

  // state | meaning
  // IDLE  | no grant; num_out keeps the last shown value
  // OWN   | one requester owns the display; hold timer running
  typedef enum logic {IDLE, OWN} state_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [PW-1:0] PRES_LAST = PW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);

  state_t         state_q, state_d;
  logic [1:0]     ptr_q, ptr_d;
  logic [PW-1:0]  pres_q, pres_d;
  logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [3:0]     gnt_q, gnt_d;
  logic [1:0]     owner_q, owner_d;
  logic           busy_q, busy_d;
  logic [31:0]    num_out_q, num_out_d;
  logic           hold_done_q, hold_done_d;

  logic           grant_new;
  logic [1:0]     new_owner;
  logic [3:0]     others;
  logic           tick;

  // First set bit of mask, scanning start, start+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    pick  = start;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = start + 2'(k);
      if (!found && mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [31:0] slice_of(input logic [127:0] d, input logic [1:0] i);
    return d[{i, 5'd0} +: 32];
  endfunction

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    pres_d     = pres_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    busy_d     = busy_q;
    num_out_d  = num_out_q;
    grant_new  = 1'b0;
    new_owner  = owner_q;
    others     = req & ~gnt_q;
    tick       = (pres_q == PRES_LAST);

    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_new = 1'b1;
          new_owner = rr_pick(req, ptr_q);
        end
      end
      OWN: begin
        if (!req[owner_q]) begin
          // A release wins over hold expiry in the same cycle.
          if (|others) begin
            grant_new = 1'b1;
            new_owner = rr_pick(others, ptr_q);
          end else begin
            state_d    = IDLE;
            gnt_d      = 4'b0000;
            busy_d     = 1'b0;
            pres_d     = '0;
            hold_cnt_d = '0;
          end
        end else if (hold_done_q && (|others)) begin
          grant_new = 1'b1;
          new_owner = rr_pick(others, owner_q + 2'd1);
        end else begin
          pres_d = tick ? '0 : pres_q + PW'(1);
          if (tick && (hold_cnt_q != HOLD_MAX))
            hold_cnt_d = hold_cnt_q + HW'(1);
          num_out_d = slice_of(data_in, owner_q);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (grant_new) begin
      state_d    = OWN;
      owner_d    = new_owner;
      gnt_d      = 4'b0001 << new_owner;
      busy_d     = 1'b1;
      ptr_d      = new_owner + 2'd1;
      pres_d     = '0;
      hold_cnt_d = '0;
      num_out_d  = slice_of(data_in, new_owner);
    end

    hold_done_d = (hold_cnt_d == HOLD_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd0;
      pres_q      <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= 4'b0000;
      owner_q     <= 2'd0;
      busy_q      <= 1'b0;
      num_out_q   <= 32'd0;
      hold_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      pres_q      <= pres_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      num_out_q   <= num_out_d;
      hold_done_q <= hold_done_d;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign num_out   = num_out_q;
  assign hold_done = hold_done_q;

endmodule

// File: tb/tb_dt_arbiter.sv
// Directed bench for dt_arbiter with TICK_DIV=4, HOLD_TICKS=3 (13-cycle hold).
module tb_dt_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] data_in;
  logic [3:0]   gnt;
  logic [1:0]   owner;
  logic         busy;
  logic [31:0]  num_out;
  logic         hold_done;

  int n_cmp = 0;
  int n_err = 0;

  dt_arbiter #(.TICK_DIV(4), .HOLD_TICKS(3)) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .gnt(gnt), .owner(owner), .busy(busy), .num_out(num_out), .hold_done(hold_done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_owner,
                         input logic e_busy, input logic [31:0] e_num);
    chk({tag, ".gnt"},     {28'd0, gnt},   {28'd0, e_gnt});
    chk({tag, ".owner"},   {30'd0, owner}, {30'd0, e_owner});
    chk({tag, ".busy"},    {31'd0, busy},  {31'd0, e_busy});
    chk({tag, ".num_out"}, num_out,        e_num);
  endtask

  initial begin
    reset   = 1'b1;
    req     = 4'b0000;
    data_in = '0;
    step(2);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk_all("idle", 4'b0000, 2'd0, 1'b0, 32'd0);
      chk("idle.hold_done", {31'd0, hold_done}, 32'd0);
    end

    // Single requester 2, data tracking, hold saturation
    data_in[95:64] = 32'h1234_5678;
    req = 4'b0100;
    step(1);
    chk_all("g2", 4'b0100, 2'd2, 1'b1, 32'h1234_5678);
    chk("g2.hold_done0", {31'd0, hold_done}, 32'd0);
    data_in[95:64] = 32'hDEAD_BEEF;
    step(1);
    chk("g2.track", num_out, 32'hDEAD_BEEF);
    step(10);
    chk("g2.hold_pre", {31'd0, hold_done}, 32'd0);
    step(1);
    chk("g2.hold_rise", {31'd0, hold_done}, 32'd1);
    chk("g2.gnt_rise", {28'd0, gnt}, 32'h4);
    step(5);
    chk("g2.hold_sat", {31'd0, hold_done}, 32'd1);
    chk("g2.gnt_kept", {28'd0, gnt}, 32'h4);

    // Reset mid-grant, then alternation between 0 and 1
    data_in[31:0]    = 32'h0000_00A0;
    data_in[63:32]   = 32'h0000_00B1;
    data_in[127:96]  = 32'h0000_00C3;
    reset = 1'b1;
    req   = 4'b0011;
    step(1);
    chk_all("rst1", 4'b0000, 2'd0, 1'b0, 32'd0);
    reset = 1'b0;
    step(1);
    chk_all("rr.g0", 4'b0001, 2'd0, 1'b1, 32'h0000_00A0);
    step(12);
    chk("rr.g0_last", {28'd0, gnt}, 32'h1);
    chk("rr.g0_hold", {31'd0, hold_done}, 32'd1);
    step(1);
    chk_all("rr.g1", 4'b0010, 2'd1, 1'b1, 32'h0000_00B1);
    chk("rr.g1_hold", {31'd0, hold_done}, 32'd0);
    step(12);
    chk("rr.g1_last", {28'd0, gnt}, 32'h2);
    step(1);
    chk_all("rr.back0", 4'b0001, 2'd0, 1'b1, 32'h0000_00A0);

    // Owner 0 releases on its 5th cycle while 3 waits
    req = 4'b1001;
    step(4);
    chk("drop.pre", {28'd0, gnt}, 32'h1);
    req = 4'b1000;
    step(1);
    chk_all("drop.g3", 4'b1000, 2'd3, 1'b1, 32'h0000_00C3);
    chk("drop.hold0", {31'd0, hold_done}, 32'd0);
    step(11);
    chk("drop.hold_pre", {31'd0, hold_done}, 32'd0);
    step(1);
    chk("drop.hold_rise", {31'd0, hold_done}, 32'd1);

    // Hand over to 1, then 1 drops as its hold completes with 2 waiting
    req = 4'b0010;
    step(1);
    chk_all("hx.g1", 4'b0010, 2'd1, 1'b1, 32'h0000_00B1);
    req = 4'b0110;
    step(11);
    chk("hx.hold_pre", {31'd0, hold_done}, 32'd0);
    step(1);
    chk("hx.hold_rise", {31'd0, hold_done}, 32'd1);
    req = 4'b0100;
    step(1);
    chk_all("hx.g2", 4'b0100, 2'd2, 1'b1, 32'hDEAD_BEEF);

    // Sole owner releases: idle with retained value
    req = 4'b0000;
    step(1);
    chk_all("rel.idle", 4'b0000, 2'd2, 1'b0, 32'hDEAD_BEEF);
    step(3);
    chk_all("rel.idle3", 4'b0000, 2'd2, 1'b0, 32'hDEAD_BEEF);

    // From idle with all requesting, pointer is last owner + 1 = 3
    req = 4'b1111;
    step(1);
    chk_all("all.g3", 4'b1000, 2'd3, 1'b1, 32'h0000_00C3);
    step(3);
    reset = 1'b1;
    step(1);
    chk_all("rst2", 4'b0000, 2'd0, 1'b0, 32'd0);
    chk("rst2.hold_done", {31'd0, hold_done}, 32'd0);
    reset = 1'b0;
    step(1);
    chk_all("rst2.g0", 4'b0001, 2'd0, 1'b1, 32'h0000_00A0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
